// File: rtl/gauss_filter_pkg.sv
// Shared constants, FSM state type and default coefficient table for the
// Gaussian pulse-shaping filter.
package gauss_filter_pkg;

  localparam int unsigned GF_SAMPLE_PER_SYMBOL = 8;
  localparam int unsigned GF_COEF_WIDTH        = 16;
  localparam int unsigned GF_NUM_TAP           = 2 * GF_SAMPLE_PER_SYMBOL + 1;
  localparam int unsigned GF_SUM_GUARD         = 5;
  localparam int unsigned GF_TAP_IDX_WIDTH     = 5;
  localparam int          GF_CENTER_COEF       = 16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Accumulator width: 5 guard bits cover up to 32 full-scale taps.
  function automatic int unsigned gf_sum_width(input int unsigned coef_width);
    return coef_width + GF_SUM_GUARD;
  endfunction

  // Reset table is a pass-through impulse on the centre tap.
  function automatic int gf_default_coef(input int k, input int num_tap);
    return (k == (num_tap - 1) / 2) ? GF_CENTER_COEF : 0;
  endfunction

endpackage

// File: rtl/gauss_tap_rom_ram.sv
// Writable coefficient table, reloaded with the default impulse on reset.
module gauss_tap_rom_ram
  import gauss_filter_pkg::*;
#(
  parameter int unsigned NUM_TAP    = GF_NUM_TAP,
  parameter int unsigned COEF_WIDTH = GF_COEF_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en_i,
  input  logic [GF_TAP_IDX_WIDTH-1:0]          wr_idx_i,
  input  logic [COEF_WIDTH-1:0]                wr_data_i,
  output logic [NUM_TAP-1:0][COEF_WIDTH-1:0]   coef_o
);

  logic [NUM_TAP-1:0][COEF_WIDTH-1:0] coef_q;

  // Addresses at or beyond NUM_TAP match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_TAP); k++) begin
        coef_q[k] <= COEF_WIDTH'(gf_default_coef(k, int'(NUM_TAP)));
      end
    end else if (wr_en_i) begin
      for (int k = 0; k < int'(NUM_TAP); k++) begin
        if (wr_idx_i == GF_TAP_IDX_WIDTH'(k)) begin
          coef_q[k] <= wr_data_i;
        end
      end
    end
  end

  assign coef_o = coef_q;

endmodule

// File: rtl/gauss_filter.sv
// Gaussian FIR on a +/-1 upsampled bit stream with per-packet tail flush.
module gauss_filter
  import gauss_filter_pkg::*;
#(
  parameter int unsigned SAMPLE_PER_SYMBOL      = GF_SAMPLE_PER_SYMBOL,
  parameter int unsigned GAUSS_FILTER_BIT_WIDTH = GF_COEF_WIDTH,
  parameter int unsigned NUM_TAP                = 2 * SAMPLE_PER_SYMBOL + 1,
  localparam int unsigned SUM_WIDTH             = gf_sum_width(GAUSS_FILTER_BIT_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bit_upsample,
  input  logic                              bit_upsample_valid,
  input  logic                              bit_upsample_valid_last,
  input  logic [GF_TAP_IDX_WIDTH-1:0]       tap_index,
  input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
  input  logic                              tap_wr,
  output logic                              busy,
  output logic signed [SUM_WIDTH-1:0]       gauss_out,
  output logic                              gauss_out_valid,
  output logic                              gauss_out_valid_last
);

  localparam int unsigned FLUSH_LEN = (NUM_TAP - 1) / 2;
  localparam int unsigned FCNT_W    = $clog2(FLUSH_LEN);

  state_e                     state_q;
  logic [NUM_TAP-1:0]         hist_q;
  logic [NUM_TAP-1:0]         mask_q;
  logic [FCNT_W-1:0]          fcnt_q;
  logic                       phase_q;
  logic                       busy_q;
  logic signed [SUM_WIDTH-1:0] out_q;
  logic                       valid_q;
  logic                       last_q;

  logic [NUM_TAP-1:0][GAUSS_FILTER_BIT_WIDTH-1:0] coef_w;

  logic                       accept_c;
  logic                       flush_shift_c;
  logic                       shift_c;
  logic                       last_flush_c;
  logic [NUM_TAP-1:0]         hist_d;
  logic [NUM_TAP-1:0]         mask_d;
  logic signed [SUM_WIDTH-1:0] sum_d;

  gauss_tap_rom_ram #(
    .NUM_TAP    (NUM_TAP),
    .COEF_WIDTH (GAUSS_FILTER_BIT_WIDTH)
  ) u_taps (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (tap_wr && (state_q == ST_IDLE)),
    .wr_idx_i  (tap_index),
    .wr_data_i (tap_value),
    .coef_o    (coef_w)
  );

  // Flush samples land on every second FLUSH cycle, starting with the second.
  assign accept_c      = bit_upsample_valid && (state_q != ST_FLUSH);
  assign flush_shift_c = (state_q == ST_FLUSH) && phase_q;
  assign shift_c       = accept_c || flush_shift_c;
  assign last_flush_c  = flush_shift_c && (fcnt_q == FCNT_W'(FLUSH_LEN - 1));

  assign hist_d = {hist_q[NUM_TAP-2:0], accept_c && bit_upsample};
  assign mask_d = {mask_q[NUM_TAP-2:0], accept_c};

  // Sum over the post-shift window so the result registers on the shift edge.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < int'(NUM_TAP); k++) begin
      if (mask_d[k]) begin
        if (hist_d[k]) sum_d = sum_d + SUM_WIDTH'($signed(coef_w[k]));
        else           sum_d = sum_d - SUM_WIDTH'($signed(coef_w[k]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hist_q  <= '0;
      mask_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= shift_c;
      last_q  <= last_flush_c;
      if (shift_c) begin
        out_q  <= sum_d;
        hist_q <= hist_d;
        mask_q <= mask_d;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q <= bit_upsample_valid_last ? ST_FLUSH : ST_RUN;
            busy_q  <= 1'b1;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept_c && bit_upsample_valid_last) begin
            state_q <= ST_FLUSH;
            fcnt_q  <= '0;
            phase_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          phase_q <= ~phase_q;
          if (flush_shift_c) fcnt_q <= fcnt_q + FCNT_W'(1);
          if (last_flush_c) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            mask_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                 = busy_q;
  assign gauss_out            = out_q;
  assign gauss_out_valid      = valid_q;
  assign gauss_out_valid_last = last_q;

endmodule

// File: tb/tb_gauss_filter.sv
// Bench for gauss_filter: packet table plus hand-written corner sequences,
// all outputs checked through an expected-value queue fed by a convolution model.
module tb_gauss_filter;

  localparam int NT = 17;
  localparam int SW = 21;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 bit_upsample;
  logic                 bit_upsample_valid;
  logic                 bit_upsample_valid_last;
  logic [4:0]           tap_index;
  logic [15:0]          tap_value;
  logic                 tap_wr;
  logic                 busy;
  logic signed [SW-1:0] gauss_out;
  logic                 gauss_out_valid;
  logic                 gauss_out_valid_last;

  gauss_filter dut (
    .clk                     (clk),
    .rst                     (rst),
    .bit_upsample            (bit_upsample),
    .bit_upsample_valid      (bit_upsample_valid),
    .bit_upsample_valid_last (bit_upsample_valid_last),
    .tap_index               (tap_index),
    .tap_value               (tap_value),
    .tap_wr                  (tap_wr),
    .busy                    (busy),
    .gauss_out               (gauss_out),
    .gauss_out_valid         (gauss_out_valid),
    .gauss_out_valid_last    (gauss_out_valid_last)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int val;
    bit last;
  } exp_t;

  typedef struct {
    int len;
    int pat;          // 0 ones, 1 alternating, 2 zeros, 3 random
    bit noise;        // junk inputs while flushing
    int exp_outputs;
  } pkt_vec_t;

  exp_t sb_q[$];
  int   coef_m[NT];
  bit   pkt_bits[64];
  int   n_vec = 0;
  int   n_err = 0;
  int   out_cnt = 0;
  int   last_cnt = 0;
  int   prev_out = 0;
  bit   chk_busy_next = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_out(input int n, input int len);
    int acc = 0;
    for (int k = 0; k < NT; k++) begin
      int j;
      j = n - k;
      if (j >= 0 && j < len) acc += pkt_bits[j] ? coef_m[k] : -coef_m[k];
    end
    return acc;
  endfunction

  function automatic void push_exp(input int n, input int len);
    exp_t e;
    e.val  = model_out(n, len);
    e.last = (n == len + 7);
    sb_q.push_back(e);
  endfunction

  task automatic set_default_model();
    for (int k = 0; k < NT; k++) coef_m[k] = (k == 8) ? 16384 : 0;
  endtask

  task automatic write_tap(input int idx, input int val);
    @(posedge clk); #1;
    tap_wr    = 1'b1;
    tap_index = 5'(idx);
    tap_value = 16'(val);
    @(posedge clk); #1;
    tap_wr    = 1'b0;
  endtask

  // Drive a packet one sample every other cycle; wr_busy also attempts writes in RUN and FLUSH.
  task automatic send_packet(input int len, input int pat, input bit noise, input bit wr_busy);
    for (int i = 0; i < len; i++) begin
      case (pat)
        0:       pkt_bits[i] = 1'b1;
        1:       pkt_bits[i] = (i % 2 == 0);
        2:       pkt_bits[i] = 1'b0;
        default: pkt_bits[i] = 1'($urandom_range(0, 1));
      endcase
    end
    for (int i = 0; i < len; i++) begin
      push_exp(i, len);
      if (i == len - 1) for (int f = 0; f < 8; f++) push_exp(len + f, len);
      @(posedge clk); #1;
      bit_upsample            = pkt_bits[i];
      bit_upsample_valid      = 1'b1;
      bit_upsample_valid_last = (i == len - 1);
      if (wr_busy && i == 1) begin
        tap_wr = 1'b1; tap_index = 5'd0; tap_value = 16'd1000;
      end
      @(posedge clk); #1;
      bit_upsample_valid      = 1'b0;
      bit_upsample_valid_last = 1'b0;
      tap_wr                  = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        check("busy_after_first_sample", int'(busy), 1);
      end
    end
    if (wr_busy) begin
      @(posedge clk); #1;
      tap_wr = 1'b1; tap_index = 5'd8; tap_value = 16'd7;
      @(posedge clk); #1;
      tap_wr = 1'b0;
    end
    if (noise) begin
      for (int c = 0; c < 9; c++) begin
        @(posedge clk); #1;
        bit_upsample            = 1'($urandom_range(0, 1));
        bit_upsample_valid      = 1'($urandom_range(0, 1));
        bit_upsample_valid_last = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      bit_upsample_valid      = 1'b0;
      bit_upsample_valid_last = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy=%0d pending=%0d, expected idle with 0 pending",
               name, busy, sb_q.size());
      sb_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  pkt_vec_t vecs[5];

  initial begin
    int out_start;
    int last_start;

    vecs[0] = '{len: 8,  pat: 0, noise: 1'b0, exp_outputs: 16};
    vecs[1] = '{len: 24, pat: 1, noise: 1'b0, exp_outputs: 32};
    vecs[2] = '{len: 1,  pat: 0, noise: 1'b0, exp_outputs: 9};
    vecs[3] = '{len: 13, pat: 3, noise: 1'b1, exp_outputs: 21};
    vecs[4] = '{len: 5,  pat: 2, noise: 1'b1, exp_outputs: 13};

    rst = 1'b1;
    bit_upsample = 1'b0; bit_upsample_valid = 1'b0; bit_upsample_valid_last = 1'b0;
    tap_index = '0; tap_value = '0; tap_wr = 1'b0;
    set_default_model();

    // Output monitor / scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (chk_busy_next) begin
          chk_busy_next = 1'b0;
          check("busy_after_valid_last", int'(busy), 0);
        end
        if (rst) begin
          prev_out = 0;
        end else if (gauss_out_valid) begin
          out_cnt++;
          if (gauss_out_valid_last) begin
            last_cnt++;
            chk_busy_next = 1'b1;
          end
          if (sb_q.size() == 0) begin
            check("unexpected_output_valid", 1, 0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("gauss_out", int'(gauss_out), e.val);
            check("gauss_out_valid_last", int'(gauss_out_valid_last), int'(e.last));
          end
          prev_out = int'(gauss_out);
        end else begin
          check("gauss_out_hold", int'(gauss_out), prev_out);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_gauss_out", int'(gauss_out), 0);
    check("reset_valid", int'(gauss_out_valid), 0);
    check("reset_valid_last", int'(gauss_out_valid_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Packet table under default coefficients.
    for (int v = 0; v < 5; v++) begin
      out_start = out_cnt;
      send_packet(vecs[v].len, vecs[v].pat, vecs[v].noise, 1'b0);
      wait_done("table_packet");
      check("table_output_count", out_cnt - out_start, vecs[v].exp_outputs);
    end

    // All taps = 1, plus out-of-range writes that must be dropped.
    for (int k = 0; k < NT; k++) begin
      write_tap(k, 1);
      coef_m[k] = 1;
    end
    write_tap(17, 999);
    write_tap(31, 999);
    out_start = out_cnt;
    send_packet(17, 2, 1'b0, 1'b0);
    wait_done("all_ones_taps");
    check("all_ones_output_count", out_cnt - out_start, 25);

    // Writes attempted in RUN and FLUSH leave the table untouched.
    out_start = out_cnt;
    send_packet(6, 3, 1'b0, 1'b1);
    wait_done("wr_while_busy");
    send_packet(4, 0, 1'b0, 1'b0);
    wait_done("after_wr_while_busy");
    check("wr_busy_output_count", out_cnt - out_start, 26);

    // Reset asserted mid-FLUSH aborts without valid_last.
    last_start = last_cnt;
    send_packet(4, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    sb_q.delete();
    check("midflush_rst_busy", int'(busy), 0);
    check("midflush_rst_gauss_out", int'(gauss_out), 0);
    check("midflush_rst_valid", int'(gauss_out_valid), 0);
    check("midflush_rst_valid_last", int'(gauss_out_valid_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_default_model();
    out_start = out_cnt;
    repeat (30) @(negedge clk);
    check("midflush_rst_no_outputs", out_cnt - out_start, 0);
    check("midflush_rst_no_valid_last", last_cnt - last_start, 0);

    // Table is back to the default impulse after reset.
    out_start = out_cnt;
    send_packet(8, 0, 1'b0, 1'b0);
    wait_done("post_reset_packet");
    check("post_reset_output_count", out_cnt - out_start, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
